// File: rtl/secure_reg_reader.sv
// Access-controlled read responder: a captured (user, address) pair is checked
// against a per-register permission mask, and repeated violations lock the block.
module secure_reg_reader #(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 4,
    parameter int MAX_VIOL = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_usr_id,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [NUM_REGS*8-1:0] reg_bank,
    input  logic [NUM_REGS*8-1:0] perm_mask,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [7:0]            rsp_data,
    output logic                  rsp_err,
    output logic [3:0]            viol_cnt,
    output logic                  locked
);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        RESP,
        LOCKED
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          usr_q, usr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [7:0]          rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;
    logic [3:0]          viol_q, viol_d;
    logic                locked_q, locked_d;

    logic                grant;
    logic [7:0]          sel_data;
    logic [7:0]          perm_row;
    logic [3:0]          viol_inc;

    // Grant and data both derive from the captured address/user; an out-of-range
    // address matches no row, so the mask is never indexed past its end.
    always_comb begin
        grant    = 1'b0;
        sel_data = 8'h00;
        perm_row = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_q == ADDR_W'(i)) begin
                perm_row = perm_mask[8*i +: 8];
                sel_data = reg_bank[8*i +: 8];
                grant    = perm_row[usr_q];
            end
        end
    end

    assign viol_inc = (viol_q == 4'hF) ? viol_q : viol_q + 4'd1;

    always_comb begin
        state_d     = state_q;
        usr_d       = usr_q;
        addr_d      = addr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        viol_d      = viol_q;
        locked_d    = locked_q;
        req_ready   = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    usr_d   = req_usr_id;
                    addr_d  = req_addr;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = !grant;
                rsp_data_d  = grant ? sel_data : 8'h00;
                if (!grant) begin
                    viol_d = viol_inc;
                    if (viol_inc >= 4'(MAX_VIOL)) begin
                        locked_d = 1'b1;
                    end
                end
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = locked_q ? LOCKED : IDLE;
                end
            end
            LOCKED: begin
                // Every request is refused without consulting the mask.
                req_ready = !rsp_valid_q;
                if (rsp_valid_q) begin
                    if (rsp_ready) begin
                        rsp_valid_d = 1'b0;
                    end
                end else if (req_valid) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_data_d  = 8'h00;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            usr_q       <= 3'd0;
            addr_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            rsp_err_q   <= 1'b0;
            viol_q      <= 4'd0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            usr_q       <= usr_d;
            addr_q      <= addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            viol_q      <= viol_d;
            locked_q    <= locked_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign viol_cnt  = viol_q;
    assign locked    = locked_q;

endmodule

// File: tb/tb_secure_reg_reader.sv
// Bench for secure_reg_reader: directed scenarios followed by randomized requests
// checked against a rule-level model of grants, violations and lockout.
module tb_secure_reg_reader;

    localparam int NUM_REGS = 8;
    localparam int ADDR_W   = 4;
    localparam int MAX_VIOL = 4;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  req_valid = 1'b0;
    logic                  req_ready;
    logic [2:0]            req_usr_id = 3'd0;
    logic [ADDR_W-1:0]     req_addr = '0;
    logic [NUM_REGS*8-1:0] reg_bank = '0;
    logic [NUM_REGS*8-1:0] perm_mask = '0;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b0;
    logic [7:0]            rsp_data;
    logic                  rsp_err;
    logic [3:0]            viol_cnt;
    logic                  locked;

    int numAsserts = 0;
    int numFails   = 0;
    int modelViol  = 0;
    bit modelLocked = 1'b0;

    secure_reg_reader #(
        .NUM_REGS(NUM_REGS),
        .ADDR_W  (ADDR_W),
        .MAX_VIOL(MAX_VIOL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_usr_id(req_usr_id),
        .req_addr  (req_addr),
        .reg_bank  (reg_bank),
        .perm_mask (perm_mask),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .viol_cnt  (viol_cnt),
        .locked    (locked)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        numAsserts++;
        assert (obs === exp) else begin
            numFails++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference rules: a read is granted only for an in-range register whose
    // mask bit for the user is set; every refusal while unlocked is a violation.
    task automatic predict(input int usr, input int addr, output logic [7:0] d, output logic e);
        logic [63:0] rowBits;
        logic [63:0] permBits;
        if (modelLocked) begin
            d = 8'h00;
            e = 1'b1;
            return;
        end
        if (addr < NUM_REGS) begin
            permBits = perm_mask >> (addr * 8 + usr);
            rowBits  = reg_bank >> (addr * 8);
        end else begin
            permBits = 64'd0;
            rowBits  = 64'd0;
        end
        if (permBits[0]) begin
            d = rowBits[7:0];
            e = 1'b0;
        end else begin
            d = 8'h00;
            e = 1'b1;
            modelViol = (modelViol >= 15) ? 15 : modelViol + 1;
            if (modelViol >= MAX_VIOL) modelLocked = 1'b1;
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("reset_rsp_valid", rsp_valid, 0);
        checkOutput("reset_req_ready", req_ready, 1);
        checkOutput("reset_rsp_data", rsp_data, 0);
        checkOutput("reset_rsp_err", rsp_err, 0);
        checkOutput("reset_viol_cnt", viol_cnt, 0);
        checkOutput("reset_locked", locked, 0);
        modelViol   = 0;
        modelLocked = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One full request/response; respMode 1 scrambles inputs during the response,
    // respMode 2 grants every user on every register during the response.
    task automatic applyStimulus(input int usr, input int addr, input int hold,
                                 input bit checkChange, input int respMode, input int checkUsr);
        logic [7:0] expData;
        logic       expErr;
        bit         lockedPath;
        @(negedge clk);
        checkOutput("req_ready_before", req_ready, 1);
        req_valid  = 1'b1;
        req_usr_id = usr[2:0];
        req_addr   = addr[ADDR_W-1:0];
        lockedPath = modelLocked;
        @(negedge clk);
        req_valid  = 1'b0;
        req_usr_id = checkUsr[2:0];
        req_addr   = ADDR_W'($urandom);
        if (!lockedPath) begin
            checkOutput("rsp_valid_in_check", rsp_valid, 0);
            checkOutput("req_ready_in_check", req_ready, 0);
            if (checkChange) begin
                reg_bank  = {$urandom(), $urandom()};
                perm_mask = {$urandom(), $urandom()};
            end
            predict(usr, addr, expData, expErr);
            @(negedge clk);
        end else begin
            predict(usr, addr, expData, expErr);
        end
        checkOutput("rsp_valid", rsp_valid, 1);
        checkOutput("rsp_data", rsp_data, expData);
        checkOutput("rsp_err", rsp_err, expErr);
        checkOutput("viol_cnt", viol_cnt, modelViol);
        checkOutput("locked", locked, modelLocked);
        checkOutput("req_ready_in_resp", req_ready, 0);
        if (respMode == 1) begin
            reg_bank  = {$urandom(), $urandom()};
            perm_mask = {$urandom(), $urandom()};
        end else if (respMode == 2) begin
            perm_mask = '1;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkOutput("hold_rsp_valid", rsp_valid, 1);
            checkOutput("hold_rsp_data", rsp_data, expData);
            checkOutput("hold_rsp_err", rsp_err, expErr);
            checkOutput("hold_req_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checkOutput("rsp_valid_after_hs", rsp_valid, 0);
        checkOutput("req_ready_after_hs", req_ready, 1);
    endtask

    localparam logic [63:0] PERM_U4_R2 = 64'h0000_0000_0010_0000;
    localparam logic [63:0] BANK_R2_A5 = 64'h1122_3344_55A5_7788;

    initial begin
        $display("[TB] starting");
        repeat (2) @(negedge clk);
        doReset();

        perm_mask = PERM_U4_R2;
        reg_bank  = BANK_R2_A5;
        applyStimulus(4, 2, 0, 1'b0, 0, 4);
        applyStimulus(3, 2, 0, 1'b0, 0, 3);
        applyStimulus(4, 2, 5, 1'b0, 0, 1);

        perm_mask = '0;
        applyStimulus(4, 2, 2, 1'b0, 2, 4);
        perm_mask = PERM_U4_R2;

        applyStimulus(4, NUM_REGS, 0, 1'b0, 0, 0);
        checkOutput("viol_after_oor", viol_cnt, 3);

        // Abort a granted request while it sits in the check cycle.
        @(negedge clk);
        req_valid  = 1'b1;
        req_usr_id = 3'd4;
        req_addr   = ADDR_W'(2);
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("midreset_in_check", rsp_valid, 0);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_rsp_valid", rsp_valid, 0);
        checkOutput("midreset_viol", viol_cnt, 0);
        checkOutput("midreset_locked", locked, 0);
        checkOutput("midreset_req_ready", req_ready, 1);
        modelViol   = 0;
        modelLocked = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("midreset_no_rsp", rsp_valid, 0);
        end

        for (int i = 0; i < MAX_VIOL; i++) applyStimulus(3, 2, 0, 1'b0, 0, 0);
        checkOutput("locked_after_max", locked, 1);
        applyStimulus(4, 2, 1, 1'b0, 0, 4);
        applyStimulus(5, 1, 0, 1'b0, 0, 4);
        checkOutput("viol_frozen", viol_cnt, MAX_VIOL);

        doReset();
        for (int n = 0; n < 150; n++) begin
            if (n % 12 == 11) doReset();
            reg_bank  = {$urandom(), $urandom()};
            perm_mask = {$urandom(), $urandom()} | {$urandom(), $urandom()};
            applyStimulus(int'($urandom_range(0, 7)), int'($urandom_range(0, 10)),
                          int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          int'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", numAsserts, numFails);
        $finish;
    end

endmodule
